// File: rtl/als_sample_sequencer_if.sv
// Request/response handshake to the SPI light-sensor reader and the sample RAM write port.
interface als_sample_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              spi_valid;
  logic              spi_ready;
  logic [7:0]        spi_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output spi_valid,
    input  spi_ready,
    input  spi_data,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    input  spi_valid,
    output spi_ready,
    output spi_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/als_sample_sequencer.sv
// Periodic sampler: requests a reading from the SPI reader each tick, stores the byte
// into a circular sample memory and publishes block averages.
module als_sample_sequencer #(
  parameter int unsigned PERIOD_CYCLES  = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   err_clr,
  als_sample_sequencer_if.master bus,
  output logic [7:0]             avg_out,
  output logic                   avg_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam int unsigned PER_W = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;
  localparam int unsigned BLK_W = (AVG_LOG2       > 0) ? AVG_LOG2               : 1;
  localparam int unsigned ACC_W = 8 + AVG_LOG2;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PERIOD,
    S_REQUEST,
    S_CAPTURE,
    S_WRITE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PER_W-1:0]   per_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [BLK_W-1:0]   blk_q;
  logic               spi_valid_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [7:0]         mem_wdata_q;
  logic               tick;
  logic               to_hit;
  logic               in_txn;
  logic [ACC_W-1:0]   sum;

  assign tick   = enable && (per_cnt_q == PER_LAST);
  assign in_txn = (state_q == S_REQUEST) || (state_q == S_CAPTURE) ||
                  (state_q == S_WRITE)   || (state_q == S_GAP);
  assign sum    = acc_q + ACC_W'(mem_wdata_q);

  assign bus.spi_valid = spi_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Free-running sample period, held at zero while sampling is disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      per_cnt_q <= '0;
    end else if (!enable || (per_cnt_q == PER_LAST)) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_q + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    to_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_PERIOD;
      end
      S_WAIT_PERIOD: begin
        if (!enable)   state_d = S_IDLE;
        else if (tick) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        if (bus.spi_ready) begin
          state_d = S_CAPTURE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_GAP;
          to_hit  = 1'b1;
        end
      end
      S_CAPTURE: state_d = S_WRITE;
      S_WRITE:   state_d = S_GAP;
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = enable ? S_WAIT_PERIOD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dwell counters restart on every entry into REQUEST / GAP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      to_cnt_q  <= ((state_q == S_REQUEST) && (state_d == S_REQUEST)) ? to_cnt_q + TO_W'(1) : '0;
      gap_cnt_q <= ((state_q == S_GAP) && (state_d == S_GAP)) ? gap_cnt_q + GAP_W'(1) : '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      blk_q       <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      spi_valid_q <= (state_d == S_REQUEST) || (state_d == S_CAPTURE);
      mem_we_q    <= (state_d == S_WRITE);
      busy        <= (state_d != S_IDLE) && (state_d != S_WAIT_PERIOD);
      avg_valid   <= 1'b0;

      // Reader data settles one cycle after ready, so sample it in CAPTURE
      if (state_q == S_CAPTURE) begin
        mem_wdata_q <= bus.spi_data;
        mem_addr_q  <= ptr_q;
      end

      if (state_q == S_WRITE) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        if (blk_q == BLK_LAST) begin
          avg_out   <= 8'(sum >> AVG_LOG2);
          avg_valid <= 1'b1;
          acc_q     <= '0;
          blk_q     <= '0;
        end else begin
          acc_q <= sum;
          blk_q <= blk_q + BLK_W'(1);
        end
      end

      // Sticky flags: a new error in the clear cycle wins
      timeout_err <= to_hit | (timeout_err & ~err_clr);
      overrun_err <= (tick & in_txn) | (overrun_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_als_sample_sequencer.sv
// Scoreboard bench for als_sample_sequencer: directed reader responses, expected writes and
// averages queued at stimulus time and checked by independent monitors.
module tb_als_sample_sequencer;

  localparam int unsigned AW = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en_a, en_b, clr_a, clr_b;
  logic [7:0] avg_a, avg_b;
  logic       avgv_a, avgv_b, busy_a, busy_b, to_a, to_b, ov_a, ov_b;

  als_sample_sequencer_if #(.ADDR_W(AW)) a_if ();
  als_sample_sequencer_if #(.ADDR_W(AW)) b_if ();

  als_sample_sequencer #(
    .PERIOD_CYCLES(64), .TIMEOUT_CYCLES(16), .GAP_CYCLES(4), .ADDR_W(AW), .AVG_LOG2(2)
  ) dut_a (
    .clk(clk), .rstn(rstn), .enable(en_a), .err_clr(clr_a), .bus(a_if.master),
    .avg_out(avg_a), .avg_valid(avgv_a), .busy(busy_a), .timeout_err(to_a), .overrun_err(ov_a)
  );

  als_sample_sequencer #(
    .PERIOD_CYCLES(8), .TIMEOUT_CYCLES(16), .GAP_CYCLES(4), .ADDR_W(AW), .AVG_LOG2(2)
  ) dut_b (
    .clk(clk), .rstn(rstn), .enable(en_b), .err_clr(clr_b), .bus(b_if.master),
    .avg_out(avg_b), .avg_valid(avgv_b), .busy(busy_b), .timeout_err(to_b), .overrun_err(ov_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_a_q[$];
  wr_t        exp_b_q[$];
  logic [7:0] exp_avg_q[$];
  logic [7:0] rd_a_q[$];

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int ready_cyc  = -100;
  int b_reqs     = 0;
  int b_writes   = 0;
  logic          prev_we_a = 1'b0;
  logic [AW-1:0] b_ptr     = '0;
  logic [7:0]    b_data    = 8'h11;
  wr_t           ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    assertions++;
    failures++;
    $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reader model for A: ready after a fixed latency, byte presented the cycle after ready
  int rd_a_phase = 0, rd_a_cnt = 0, rd_a_lat = 10;
  initial begin
    a_if.spi_ready = 1'b0;
    a_if.spi_data  = 8'hEE;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        rd_a_phase = 0; rd_a_cnt = 0; a_if.spi_ready = 1'b0;
      end else begin
        case (rd_a_phase)
          0: begin
            if (a_if.spi_valid && rd_a_q.size() > 0) begin
              rd_a_cnt++;
              if (rd_a_cnt == rd_a_lat) begin a_if.spi_ready = 1'b1; rd_a_phase = 1; end
            end else rd_a_cnt = 0;
          end
          1: begin
            a_if.spi_ready = 1'b0;
            a_if.spi_data  = rd_a_q.pop_front();
            rd_a_cnt = 0; rd_a_phase = 2;
          end
          default: begin a_if.spi_data = 8'hEE; rd_a_phase = 0; end
        endcase
      end
    end
  end

  // Reader model for B: always answers after 12 cycles; expected write queued as data is issued
  int rd_b_phase = 0, rd_b_cnt = 0;
  initial begin
    b_if.spi_ready = 1'b0;
    b_if.spi_data  = 8'hEE;
    forever begin
      @(posedge clk); #1;
      case (rd_b_phase)
        0: begin
          if (b_if.spi_valid) begin
            rd_b_cnt++;
            if (rd_b_cnt == 1)  b_reqs++;
            if (rd_b_cnt == 12) begin b_if.spi_ready = 1'b1; rd_b_phase = 1; end
          end else rd_b_cnt = 0;
        end
        1: begin
          b_if.spi_ready = 1'b0;
          b_if.spi_data  = b_data;
          exp_b_q.push_back(wr_t'{addr: b_ptr, data: b_data});
          b_ptr  = b_ptr + AW'(1);
          b_data = b_data + 8'h11;
          rd_b_cnt = 0; rd_b_phase = 2;
        end
        default: begin b_if.spi_data = 8'hEE; rd_b_phase = 0; end
      endcase
    end
  end

  // Monitor A: writes, write latency from ready, averages
  always @(negedge clk) begin
    cyc++;
    if (a_if.spi_ready) ready_cyc = cyc;
    if (a_if.mem_we) begin
      check("a_we_latency", 32'(cyc - ready_cyc), 32'd2);
      if (exp_a_q.size() == 0) fail("a_unexpected_write", 32'(a_if.mem_addr), -1);
      else begin
        ea = exp_a_q.pop_front();
        check("a_write", 32'({a_if.mem_addr, a_if.mem_wdata}), 32'({ea.addr, ea.data}));
      end
    end
    if (avgv_a) begin
      check("a_avg_follows_we", 32'(prev_we_a), 32'd1);
      if (exp_avg_q.size() == 0) fail("a_unexpected_avg", 32'(avg_a), -1);
      else check("a_avg_out", 32'(avg_a), 32'(exp_avg_q.pop_front()));
    end
    prev_we_a = a_if.mem_we;
  end

  // Monitor B: every write must match a delivered reader byte
  always @(negedge clk) begin
    if (b_if.mem_we) begin
      b_writes++;
      if (exp_b_q.size() == 0) fail("b_unexpected_write", 32'(b_if.mem_addr), -1);
      else begin
        eb = exp_b_q.pop_front();
        check("b_write", 32'({b_if.mem_addr, b_if.mem_wdata}), 32'({eb.addr, eb.data}));
      end
    end
  end

  task automatic wait_a_valid(input int limit, output int n);
    n = 0;
    while (!a_if.spi_valid && n < limit) begin @(posedge clk); #1; n++; end
    if (!a_if.spi_valid) fail("a_valid_wait_expired", n, limit);
  endtask

  task automatic wait_a_drain(input int limit);
    int n = 0;
    while ((exp_a_q.size() != 0 || exp_avg_q.size() != 0) && n < limit) begin
      @(negedge clk); n++;
    end
    if (exp_a_q.size() != 0 || exp_avg_q.size() != 0) fail("a_drain_expired", exp_a_q.size(), 0);
  endtask

  task automatic push_a(input logic [AW-1:0] addr, input logic [7:0] data);
    rd_a_q.push_back(data);
    exp_a_q.push_back(wr_t'{addr: addr, data: data});
  endtask

  initial begin
    int n, cnt;
    rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Test 1: reach REQUEST, then reset asynchronously mid-cycle
    @(posedge clk); #1 en_a = 1'b1;
    wait_a_valid(200, n);
    check("t1_valid_delay_from_reset", 32'(n), 32'd64);
    @(negedge clk); #2;
    check("t1_valid_before_reset", 32'(a_if.spi_valid), 32'd1);
    check("t1_busy_before_reset", 32'(busy_a), 32'd1);
    rstn = 1'b0; en_a = 1'b0;
    #1;
    check("t1_async_reset_outputs",
          32'({a_if.spi_valid, a_if.mem_we, a_if.mem_addr, a_if.mem_wdata,
               avg_a, avgv_a, busy_a, to_a, ov_a}), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Tests 2 and 3: four ramp samples, then five 0xFF samples wrapping the pointer
    push_a(2'd0, 8'h10); push_a(2'd1, 8'h20); push_a(2'd2, 8'h30); push_a(2'd3, 8'h40);
    exp_avg_q.push_back(8'h28);
    push_a(2'd0, 8'hFF); push_a(2'd1, 8'hFF); push_a(2'd2, 8'hFF); push_a(2'd3, 8'hFF);
    exp_avg_q.push_back(8'hFF);
    push_a(2'd0, 8'hFF);
    @(posedge clk); #1 en_a = 1'b1;
    wait_a_valid(200, n);
    check("t1_first_valid_after_release", 32'(n), 32'd64);
    wait_a_drain(1200);

    // Test 4: reader silent -> timeout after exactly 16 request cycles
    wait_a_valid(200, n);
    n = 0;
    while (a_if.spi_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t4_valid_high_cycles", 32'(n), 32'd16);
    check("t4_timeout_err_set", 32'(to_a), 32'd1);
    check("t4_busy_in_gap", 32'(busy_a), 32'd1);
    clr_a = 1'b1;
    @(posedge clk); #1 clr_a = 1'b0;
    check("t4_timeout_err_cleared", 32'(to_a), 32'd0);
    check("t4_no_overrun", 32'(ov_a), 32'd0);

    // Test 6: drop enable during REQUEST; write still lands at the retained pointer
    push_a(2'd1, 8'h08);
    wait_a_valid(200, n);
    en_a = 1'b0;
    n = 0;
    while (!a_if.mem_we && n < 50) begin @(negedge clk); n++; end
    if (!a_if.mem_we) fail("t6_write_wait_expired", n, 50);
    n = 0;
    @(negedge clk);
    while (busy_a && n < 20) begin n++; @(negedge clk); end
    check("t6_gap_cycles", 32'(n), 32'd4);
    cnt = 0;
    repeat (200) begin @(negedge clk); if (a_if.spi_valid || busy_a) cnt++; end
    check("t6_idle_after_disable", 32'(cnt), 32'd0);

    // Accumulator kept 0xFF+0x08 across the pause: (0xFF+0x08+0x01+0x02)>>2 = 0x42
    push_a(2'd2, 8'h01); push_a(2'd3, 8'h02);
    exp_avg_q.push_back(8'h42);
    @(posedge clk); #1 en_a = 1'b1;
    wait_a_drain(400);
    en_a = 1'b0;
    check("a_scoreboard_empty", 32'(exp_a_q.size()), 32'd0);

    // Test 5: period shorter than a transaction -> overrun, one write per request
    @(posedge clk); #1 en_b = 1'b1;
    repeat (200) @(posedge clk);
    #1 en_b = 1'b0;
    n = 0;
    while (busy_b && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check("t5_busy_cleared", 32'(busy_b), 32'd0);
    check("t5_overrun_err", 32'(ov_b), 32'd1);
    check("t5_no_timeout", 32'(to_b), 32'd0);
    check("t5_several_requests", 32'(b_reqs >= 5), 32'd1);
    check("t5_writes_eq_requests", 32'(b_writes), 32'(b_reqs));
    check("t5_scoreboard_empty", 32'(exp_b_q.size()), 32'd0);
    clr_b = 1'b1;
    @(posedge clk); #1 clr_b = 1'b0;
    check("t5_overrun_cleared", 32'(ov_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/als_sample_sequencer.md
Name: als_sample_sequencer

Overview:
- Periodic scheduler for the 16-bit SPI light-sensor reader.
- On each sample tick it asserts the reader's valid and waits for its ready. It then captures the 8-bit result, writes it into a circular sample memory and produces block averages.
- It enforces a minimum deselect gap between frames and recovers from a reader that never completes. It sits between the SPI reader and the sample RAM / display logic.

Parameters:
- PERIOD_CYCLES, 100000, clk cycles between sample ticks (>= GAP_CYCLES+TIMEOUT_CYCLES+4)
- TIMEOUT_CYCLES, 1024, max cycles in REQUEST waiting for spi_ready
- GAP_CYCLES, 8, cycles with spi_valid low after every transaction
- ADDR_W, 4, sample memory address width (depth 2^ADDR_W)
- AVG_LOG2, 2, block average over 2^AVG_LOG2 samples

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  1 = periodic sampling runs
- spi_valid  out  1  request to SPI reader, held until done/timeout
- spi_ready  in  1  reader frame complete
- spi_data  in  8  reader result byte
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  sample byte
- avg_out  out  8  last block average
- avg_valid  out  1  one-cycle pulse when avg_out updates
- busy  out  1  1 in any state except IDLE/WAIT_PERIOD
- timeout_err  out  1  sticky, a request timed out
- overrun_err  out  1  sticky, tick arrived while busy
- err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0: spi_valid, mem_we, mem_addr, mem_wdata, avg_out, avg_valid, busy, timeout_err, overrun_err. Period counter, timeout counter, gap counter and accumulator also 0.
- Period counter runs only while enable=1. It counts 0..PERIOD_CYCLES-1 and asserts tick when the count equals PERIOD_CYCLES-1, then wraps to 0. enable=0 holds the counter at 0.
- States:
  - IDLE: if enable, go to WAIT_PERIOD.
  - WAIT_PERIOD: on tick go to REQUEST; if enable=0, go to IDLE.
  - REQUEST: spi_valid=1; timeout counter increments each cycle.
    - spi_ready=1 goes to CAPTURE.
    - Count reaching TIMEOUT_CYCLES-1 without spi_ready: set timeout_err, drop spi_valid, go to GAP. No memory write.
  - CAPTURE (1 cycle): spi_valid still 1. Register spi_data here, not in the ready cycle, because reader data settles one cycle after ready. Go to WRITE.
  - WRITE (1 cycle): spi_valid=0, mem_we=1, mem_wdata=captured byte, mem_addr=current pointer. Pointer increments after the write and wraps 2^ADDR_W-1 -> 0. The byte is added to the accumulator. Go to GAP.
  - GAP: spi_valid=0 for GAP_CYCLES cycles, then WAIT_PERIOD if enable, else IDLE.
- Latency: spi_ready seen at cycle N gives mem_we at cycle N+2.
- Average:
  - Accumulator is 8+AVG_LOG2 bits wide.
  - On the 2^AVG_LOG2-th write: avg_out = (acc + byte) >> AVG_LOG2 (truncating), avg_valid pulses 1 cycle (same cycle as mem_we + 1), and the accumulator clears.
  - Timed-out samples do not count toward the block.
- Tick while busy (REQUEST..GAP): tick is dropped and overrun_err is set. No queuing.
- enable falling mid-transaction: the transaction completes through WRITE/GAP (or timeout), then goes to IDLE. The pointer and accumulator are retained.
- err_clr=1 clears the sticky flags. If err_clr and a new error occur in the same cycle, set wins.
- spi_ready ignored outside REQUEST.
- mem_we and avg_valid are never asserted outside WRITE / the following cycle.

Test Plan (PERIOD_CYCLES=64, TIMEOUT_CYCLES=16, GAP_CYCLES=4, ADDR_W=2, AVG_LOG2=2):
1. Reset mid-REQUEST with spi_valid=1: pull rstn low -> all outputs 0 immediately, no clock needed. After release and enable=1, the first spi_valid rises 64 cycles later.
2. Reader model returns 0x10,0x20,0x30,0x40, ready 10 cycles after valid each time -> writes addr 0,1,2,3 with those bytes, mem_we 2 cycles after ready. avg_out=0x28 with a single avg_valid pulse.
3. Five more samples 0xFF -> addr wraps 3->0. The block average is 0xFF (accumulator 0x3FC, no overflow). The fifth sample lands in a new block.
4. Reader never asserts ready -> spi_valid high exactly 16 cycles, then low. timeout_err=1, no mem_we, pointer unchanged. err_clr pulse -> timeout_err=0.
5. Override to PERIOD_CYCLES=8 with reader latency 12 -> overrun_err=1. Each transaction still completes with exactly one write.
6. Drop enable during REQUEST; ready arrives -> write occurs, 4-cycle gap, then IDLE. busy=0 and no further spi_valid.
